mul_sequencer: RTL and testbench



---
 rtl/mul_seq_pkg.sv | 20 ++
 rtl/mul_shift_add_dp.sv | 49 ++++
 rtl/mul_sequencer.sv | 107 ++++++++++
 tb/tb_mul_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// Shared types and sizing for the shift-and-add multiply sequencer.
// Optional feature macro: MUL_EARLY_EXIT_EN (early termination once the multiplier runs out of set bits).
package mul_seq_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Counter must be able to hold WIDTH itself, hence WIDTH+1 codes.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

    localparam int unsigned DEFAULT_CNT_WIDTH = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/mul_shift_add_dp.sv
// Datapath for the multiply sequencer: multiplicand/multiplier/accumulator
// registers with a single 2*WIDTH adder, driven by load/step strobes.
module mul_shift_add_dp
    import mul_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               mp_shift_zero
);

    logic [2*WIDTH-1:0] mc;
    logic [WIDTH-1:0]   mp;
    logic [2*WIDTH-1:0] acc;

    // NOTE: acc_next gets its default before the conditional so no latch is inferred.
    always_comb begin
        acc_next = acc;
        if (mp[0]) begin
            acc_next = acc + mc;
        end
    end

    assign mp_shift_zero = ((mp >> 1) == '0);

    // NOTE: register state uses non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mc  <= '0;
            mp  <= '0;
            acc <= '0;
        end else if (load) begin
            mc  <= {{WIDTH{1'b0}}, multiplicand};
            mp  <= multiplier;
            acc <= '0;
        end else if (step) begin
            acc <= acc_next;
            mc  <= mc << 1;
            mp  <= mp >> 1;
        end
    end

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle unsigned multiply controller: FSM, stall and done logic around mul_shift_add_dp.
// Define MUL_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are all zero.
module mul_sequencer
    import mul_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] OPERAND1,
    input  logic [WIDTH-1:0] OPERAND2,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic [WIDTH-1:0] RESULT_HI,
    output logic             STALL
);

    localparam int unsigned     CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

`ifdef MUL_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               load;
    logic               step;
    logic               last_iter;
    logic               skip_run;
    logic               mp_shift_zero;
    logic [2*WIDTH-1:0] acc_next;

    assign load      = (state == IDLE) && START;
    assign step      = (state == RUN);
    assign last_iter = (cnt == LAST_CNT) || (EARLY_EXIT && mp_shift_zero);
    assign skip_run  = EARLY_EXIT && (OPERAND2 == '0);

    assign STALL = load || (state == RUN);

    mul_shift_add_dp #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk          (CLK),
        .rst          (RESET),
        .load         (load),
        .step         (step),
        .multiplicand (OPERAND1),
        .multiplier   (OPERAND2),
        .acc_next     (acc_next),
        .mp_shift_zero(mp_shift_zero)
    );

    // The product registers only change on entry to FINISH, so RESULT stays
    // stable for the CPU across the whole of the next multiply.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            cnt       <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            RESULT    <= '0;
            RESULT_HI <= '0;
        end else begin
            case (state)
                IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        cnt <= '0;
                        if (skip_run) begin
                            state     <= FINISH;
                            DONE      <= 1'b1;
                            RESULT    <= '0;
                            RESULT_HI <= '0;
                        end else begin
                            state <= RUN;
                            BUSY  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        state                 <= FINISH;
                        BUSY                  <= 1'b0;
                        DONE                  <= 1'b1;
                        {RESULT_HI, RESULT}   <= acc_next;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    DONE  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: directed multiplies, held START, ignored START and reset abort.
module tb_mul_sequencer;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       START = 1'b0;
    logic [7:0] OPERAND1 = '0;
    logic [7:0] OPERAND2 = '0;
    logic       BUSY;
    logic       DONE;
    logic [7:0] RESULT;
    logic [7:0] RESULT_HI;
    logic       STALL;

`ifdef MUL_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    mul_sequencer #(.WIDTH(8)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .START    (START),
        .OPERAND1 (OPERAND1),
        .OPERAND2 (OPERAND2),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .RESULT   (RESULT),
        .RESULT_HI(RESULT_HI),
        .STALL    (STALL)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        int         lat;
        int         e0;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int dones = 0;
    int pushed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic int lat(input int full, input int early);
        return EE ? early : full;
    endfunction

    task automatic push(input logic [7:0] lo, input logic [7:0] hi, input int latency, input int e0);
        exp_t e;
        e.lo  = lo;
        e.hi  = hi;
        e.lat = latency;
        e.e0  = e0;
        sb.push_back(e);
        pushed++;
    endtask

    // Raise START for one edge from IDLE; the next rising edge is the accepting edge E0.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input bit expect_result,
                         input logic [7:0] lo, input logic [7:0] hi, input int latency);
        OPERAND1 = a;
        OPERAND2 = b;
        START    = 1'b1;
        if (expect_result) push(lo, hi, latency, cyc + 1);
        #1;
        check("stall_with_start", STALL, 1);
        @(posedge CLK);
        #1;
        START = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || BUSY || DONE) && n < 60) begin
            tick();
            n++;
        end
        check("drain_in_time", sb.size(), 0);
    endtask

    // Latency is counted as in the DONE cycle index: cycle holding START is 0,
    // so DONE raised by the edge k after E0 is reported as k+1.
    always @(negedge CLK) begin
        if (!RESET && DONE) begin
            dones++;
            check("stall_low_in_done", STALL, 0);
            if (sb.size() == 0) begin
                check("done_without_request", DONE, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result_lo", RESULT, e.lo);
                check("result_hi", RESULT_HI, e.hi);
                check("done_latency", cyc - e.e0 + 1, e.lat);
            end
        end
    end

    initial begin
        int busy_cycles;
        int e0_second;
        int n;

        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_busy", BUSY, 0);
        check("reset_done", DONE, 0);
        check("reset_stall", STALL, 0);
        check("reset_result", RESULT, 0);
        check("reset_result_hi", RESULT_HI, 0);
        RESET = 1'b0;
        tick();

        // 5 x 3 with a single-cycle START; also count BUSY cycles.
        issue(8'd5, 8'd3, 1'b1, 8'h0F, 8'h00, lat(9, 3));
        busy_cycles = 0;
        n = 0;
        while (!DONE && n < 30) begin
            if (BUSY) busy_cycles++;
            tick();
            n++;
        end
        check("busy_cycles", busy_cycles, EE ? 2 : 8);
        wait_idle();
        repeat (2) tick();
        check("result_held", RESULT, 8'h0F);

        issue(8'd255, 8'd255, 1'b1, 8'h01, 8'hFE, lat(9, 9));
        wait_idle();

        issue(8'd9, 8'd0, 1'b1, 8'h00, 8'h00, lat(9, 1));
        wait_idle();

        issue(8'd7, 8'd1, 1'b1, 8'h07, 8'h00, lat(9, 2));
        wait_idle();

        // 12 x 10 with a stray START mid-RUN that must be ignored.
        issue(8'd12, 8'd10, 1'b1, 8'h78, 8'h00, lat(9, 5));
        check("result_held_during_run", RESULT, 8'h07);
        check("busy_in_run", BUSY, 1);
        OPERAND1 = 8'd2;
        OPERAND2 = 8'd2;
        START    = 1'b1;
        tick();
        START = 1'b0;
        wait_idle();
        repeat (3) tick();

        // START held: 6 x 7, then operands change after acceptance to 11 x 13.
        OPERAND1 = 8'd6;
        OPERAND2 = 8'd7;
        START    = 1'b1;
        push(8'h2A, 8'h00, lat(9, 4), cyc + 1);
        e0_second = cyc + 1 + (EE ? 5 : 10);
        tick();
        OPERAND1 = 8'd11;
        OPERAND2 = 8'd13;
        push(8'h8F, 8'h00, lat(9, 5), e0_second);
        n = 0;
        while (cyc < e0_second && n < 30) begin
            tick();
            n++;
        end
        START = 1'b0;
        wait_idle();

        // 200 x 200 aborted by RESET in RUN cycle 4, then 3 x 4 right after release.
        issue(8'd200, 8'd200, 1'b0, 8'h00, 8'h00, 0);
        repeat (3) tick();
        check("busy_before_abort", BUSY, 1);
        RESET = 1'b1;
        #1;
        check("abort_busy", BUSY, 0);
        check("abort_done", DONE, 0);
        check("abort_stall", STALL, 0);
        check("abort_result", RESULT, 0);
        check("abort_result_hi", RESULT_HI, 0);
        repeat (2) tick();
        check("abort_done_held", DONE, 0);
        check("abort_result_held", RESULT, 0);
        RESET = 1'b0;
        issue(8'd3, 8'd4, 1'b1, 8'h0C, 8'h00, lat(9, 4));
        wait_idle();
        repeat (12) tick();

        check("done_pulse_count", dones, pushed);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
